// File: rtl/dsp48_pkg.sv
// dsp48_pkg: constants and types shared by the DSP48A1 operand pipeline.
//   MAX_DEPTH / MAX_CH / MAX_WIDTH : legal parameter ceilings for dsp_pipe_reg
//   *_WIDTH                        : native operand widths of the slice
//   ce_policy_t                    : what a stage does on a cycle with ce low
package dsp48_pkg;

  localparam int MAX_DEPTH = 4;
  localparam int MAX_CH    = 4;
  localparam int MAX_WIDTH = 48;

  localparam int A_WIDTH = 18;
  localparam int B_WIDTH = 18;
  localparam int C_WIDTH = 48;
  localparam int P_WIDTH = 48;
  localparam int M_WIDTH = 36;

  localparam int FILL_W = 3;

  // ZERO empties the pipe on ce low (legacy); HOLD stalls it.
  typedef enum logic {
    CE_POLICY_HOLD = 1'b0,
    CE_POLICY_ZERO = 1'b1
  } ce_policy_t;

  function automatic ce_policy_t to_ce_policy(input int ce_zero);
    return (ce_zero != 0) ? CE_POLICY_ZERO : CE_POLICY_HOLD;
  endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// dsp_pipe_stage: one register stage carrying a data word and its valid bit.
//   clk     : rising-edge clock
//   i_clr   : synchronous clear of data and valid (highest priority)
//   i_en    : load i_data/i_valid; when low and not cleared, hold
//   i_data  : DATA_W-bit word from the previous stage
//   i_valid : valid bit from the previous stage
//   o_data  : registered word
//   o_valid : registered valid bit
module dsp_pipe_stage
  import dsp48_pkg::*;
#(
  parameter int DATA_W = A_WIDTH
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  always_ff @(posedge clk) begin
    if (i_clr) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_en) begin
      o_data  <= i_data;
      o_valid <= i_valid;
    end
  end

endmodule

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: 0..4 stage multi-lane operand pipeline with per-stage valid,
// selectable ce-low policy, synchronous flush and an occupancy count.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   ce        : clock enable for all stages
//   flush     : synchronous clear of all stages (beats ce)
//   in_data   : NUM_CH lanes, lane k at [k*WIDTH +: WIDTH]
//   in_valid  : qualifies in_data
//   out_data  : last-stage data (in_data when DEPTH = 0)
//   out_valid : last-stage valid (in_valid when DEPTH = 0)
//   fill      : number of stages holding a valid word
module dsp_pipe_reg
  import dsp48_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int NUM_CH  = 1,
  parameter int DEPTH   = 1,
  parameter int CE_ZERO = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    flush,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic [FILL_W-1:0]       fill
);

  localparam int         DW        = NUM_CH * WIDTH;
  localparam ce_policy_t CE_POLICY = to_ce_policy(CE_ZERO);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("dsp_pipe_reg: WIDTH out of range 1..48");
  end
  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("dsp_pipe_reg: NUM_CH out of range 1..4");
  end
  if (DEPTH < 0 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("dsp_pipe_reg: DEPTH out of range 0..4");
  end
  if (CE_ZERO != 0 && CE_ZERO != 1) begin : g_bad_ce
    $error("dsp_pipe_reg: CE_ZERO must be 0 or 1");
  end

  if (DEPTH == 0) begin : g_bypass
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign fill      = '0;

    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, ce, flush};
  end else begin : g_pipe
    logic              w_clr;
    logic [DW-1:0]     w_data [DEPTH+1];
    logic [DEPTH:0]    w_valid;
    logic [FILL_W-1:0] r_fill;

    // Under the ZERO policy a ce-low cycle is just another clear.
    assign w_clr = rst | flush | (~ce & (CE_POLICY == CE_POLICY_ZERO));

    assign w_data[0]  = in_data;
    assign w_valid[0] = in_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      dsp_pipe_stage #(.DATA_W(DW)) u_stage (
        .clk     (clk),
        .i_clr   (w_clr),
        .i_en    (ce),
        .i_data  (w_data[i]),
        .i_valid (w_valid[i]),
        .o_data  (w_data[i+1]),
        .o_valid (w_valid[i+1])
      );
    end

    // Incremental occupancy: one word may enter and one leave per shift.
    always_ff @(posedge clk) begin
      if (w_clr) begin
        r_fill <= '0;
      end else if (ce) begin
        r_fill <= r_fill + {{(FILL_W-1){1'b0}}, in_valid}
                         - {{(FILL_W-1){1'b0}}, w_valid[DEPTH]};
      end
    end

    assign out_data  = w_data[DEPTH];
    assign out_valid = w_valid[DEPTH];
    assign fill      = r_fill;
  end

endmodule

// File: tb/tb_dsp_pipe_reg.sv
module tb_dsp_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // group A: DEPTH=2, shared stimulus, ZERO and HOLD policies side by side
  logic        a_rst, a_ce, a_flush, a_valid;
  logic [17:0] a_data;
  logic [17:0] z_data, h_data;
  logic        z_valid, h_valid;
  logic [2:0]  z_fill, h_fill;

  dsp_pipe_reg #(.WIDTH(18), .NUM_CH(1), .DEPTH(2), .CE_ZERO(1)) u_d2z (
    .clk(clk), .rst(a_rst), .ce(a_ce), .flush(a_flush),
    .in_data(a_data), .in_valid(a_valid),
    .out_data(z_data), .out_valid(z_valid), .fill(z_fill));

  dsp_pipe_reg #(.WIDTH(18), .NUM_CH(1), .DEPTH(2), .CE_ZERO(0)) u_d2h (
    .clk(clk), .rst(a_rst), .ce(a_ce), .flush(a_flush),
    .in_data(a_data), .in_valid(a_valid),
    .out_data(h_data), .out_valid(h_valid), .fill(h_fill));

  // group B: DEPTH=3, two lanes
  logic        b_rst, b_ce, b_flush, b_valid;
  logic [35:0] b_data, b_out;
  logic        b_ov;
  logic [2:0]  b_fill;

  dsp_pipe_reg #(.WIDTH(18), .NUM_CH(2), .DEPTH(3), .CE_ZERO(1)) u_d3 (
    .clk(clk), .rst(b_rst), .ce(b_ce), .flush(b_flush),
    .in_data(b_data), .in_valid(b_valid),
    .out_data(b_out), .out_valid(b_ov), .fill(b_fill));

  // group C: DEPTH=4
  logic        c_rst, c_ce, c_flush, c_valid;
  logic [17:0] c_data, c_out;
  logic        c_ov;
  logic [2:0]  c_fill;

  dsp_pipe_reg #(.WIDTH(18), .NUM_CH(1), .DEPTH(4), .CE_ZERO(1)) u_d4 (
    .clk(clk), .rst(c_rst), .ce(c_ce), .flush(c_flush),
    .in_data(c_data), .in_valid(c_valid),
    .out_data(c_out), .out_valid(c_ov), .fill(c_fill));

  // group D: DEPTH=0 bypass, two lanes
  logic        d_rst, d_ce, d_flush, d_valid;
  logic [35:0] d_data, d_out;
  logic        d_ov;
  logic [2:0]  d_fill;

  dsp_pipe_reg #(.WIDTH(18), .NUM_CH(2), .DEPTH(0), .CE_ZERO(1)) u_d0 (
    .clk(clk), .rst(d_rst), .ce(d_ce), .flush(d_flush),
    .in_data(d_data), .in_valid(d_valid),
    .out_data(d_out), .out_valid(d_ov), .fill(d_fill));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input string row,
                        input logic rst, input logic fl, input logic ce,
                        input logic [17:0] d, input logic v,
                        input logic [17:0] zd, input logic zv, input logic [2:0] zf,
                        input logic [17:0] hd, input logic hv, input logic [2:0] hf);
    a_rst   = rst;
    a_flush = fl;
    a_ce    = ce;
    a_data  = d;
    a_valid = v;
    tick();
    check({row, " zero.data"},  64'(z_data),  64'(zd));
    check({row, " zero.valid"}, 64'(z_valid), 64'(zv));
    check({row, " zero.fill"},  64'(z_fill),  64'(zf));
    check({row, " hold.data"},  64'(h_data),  64'(hd));
    check({row, " hold.valid"}, 64'(h_valid), 64'(hv));
    check({row, " hold.fill"},  64'(h_fill),  64'(hf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b_rst = 1'b1; b_ce = 1'b0; b_flush = 1'b0; b_valid = 1'b0; b_data = '0;
    c_rst = 1'b1; c_ce = 1'b0; c_flush = 1'b0; c_valid = 1'b0; c_data = '0;
    d_rst = 1'b0; d_ce = 1'b0; d_flush = 1'b0; d_valid = 1'b0; d_data = '0;

    // reset held 3 cycles with all-ones input, then release
    //     row    rst fl ce data        v   zero: data      v  fill  hold: data      v  fill
    step_a("A01", 1, 0, 1, 18'h3FFFF, 1,  18'h00000, 0, 3'd0,  18'h00000, 0, 3'd0);
    step_a("A02", 1, 0, 1, 18'h3FFFF, 1,  18'h00000, 0, 3'd0,  18'h00000, 0, 3'd0);
    step_a("A03", 1, 0, 1, 18'h3FFFF, 1,  18'h00000, 0, 3'd0,  18'h00000, 0, 3'd0);
    step_a("A04", 0, 0, 1, 18'h3FFFF, 1,  18'h00000, 0, 3'd1,  18'h00000, 0, 3'd1);
    step_a("A05", 0, 0, 1, 18'h00005, 1,  18'h3FFFF, 1, 3'd2,  18'h3FFFF, 1, 3'd2);
    step_a("A06", 0, 0, 1, 18'h00006, 1,  18'h00005, 1, 3'd2,  18'h00005, 1, 3'd2);
    // ce low for two cycles: ZERO empties, HOLD stalls
    step_a("A07", 0, 0, 0, 18'h00077, 1,  18'h00000, 0, 3'd0,  18'h00005, 1, 3'd2);
    step_a("A08", 0, 0, 0, 18'h00077, 1,  18'h00000, 0, 3'd0,  18'h00005, 1, 3'd2);
    step_a("A09", 0, 0, 1, 18'h00011, 1,  18'h00000, 0, 3'd1,  18'h00006, 1, 3'd2);
    step_a("A10", 0, 0, 1, 18'h00022, 1,  18'h00011, 1, 3'd2,  18'h00011, 1, 3'd2);
    // flush with ce high: 9 must not be captured
    step_a("A11", 0, 1, 1, 18'h00009, 1,  18'h00000, 0, 3'd0,  18'h00000, 0, 3'd0);
    // bubble pattern 1,0,1 with data 7,8,9
    step_a("A12", 0, 0, 1, 18'h00007, 1,  18'h00000, 0, 3'd1,  18'h00000, 0, 3'd1);
    step_a("A13", 0, 0, 1, 18'h00008, 0,  18'h00007, 1, 3'd1,  18'h00007, 1, 3'd1);
    step_a("A14", 0, 0, 1, 18'h00009, 1,  18'h00008, 0, 3'd1,  18'h00008, 0, 3'd1);
    step_a("A15", 0, 0, 1, 18'h00000, 0,  18'h00009, 1, 3'd1,  18'h00009, 1, 3'd1);
    step_a("A16", 0, 0, 1, 18'h00000, 0,  18'h00000, 0, 3'd0,  18'h00000, 0, 3'd0);

    // streaming through 3 stages, two lanes
    b_rst = 1'b0;
    b_ce  = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      b_data  = {18'(99 + n), 18'(n)};
      b_valid = 1'b1;
      tick();
      check($sformatf("B%0d data", n),  64'(b_out),
            (n >= 3) ? 64'({18'(97 + n), 18'(n - 2)}) : 64'd0);
      check($sformatf("B%0d valid", n), 64'(b_ov), (n >= 3) ? 64'd1 : 64'd0);
      check($sformatf("B%0d fill", n),  64'(b_fill), (n >= 3) ? 64'd3 : 64'(n));
    end

    // fill to DEPTH=4, one more word keeps it full, then flush with ce high
    c_rst = 1'b0;
    c_ce  = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      c_data  = 18'(n);
      c_valid = 1'b1;
      tick();
      check($sformatf("C%0d data", n), 64'(c_out), (n >= 4) ? 64'(n - 3) : 64'd0);
      check($sformatf("C%0d fill", n), 64'(c_fill), (n >= 4) ? 64'd4 : 64'(n));
    end
    c_flush = 1'b1;
    c_data  = 18'd9;
    tick();
    check("C flush data",  64'(c_out),  64'd0);
    check("C flush valid", 64'(c_ov),   64'd0);
    check("C flush fill",  64'(c_fill), 64'd0);
    c_flush = 1'b0;
    c_data  = '0;
    c_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      check($sformatf("C post%0d data", n),  64'(c_out),  64'd0);
      check($sformatf("C post%0d valid", n), 64'(c_ov),   64'd0);
      check($sformatf("C post%0d fill", n),  64'(c_fill), 64'd0);
    end

    // bypass: outputs follow inputs within the same cycle, controls ignored
    for (int k = 0; k < 8; k++) begin
      logic [35:0] exp_d;
      logic        exp_v;
      exp_d   = 36'({$urandom(), $urandom()});
      exp_v   = 1'($urandom_range(0, 1));
      d_data  = exp_d;
      d_valid = exp_v;
      d_rst   = k[0];
      d_ce    = k[1];
      d_flush = k[2];
      #1;
      check($sformatf("D%0d data", k),  64'(d_out),  64'(exp_d));
      check($sformatf("D%0d valid", k), 64'(d_ov),   64'(exp_v));
      check($sformatf("D%0d fill", k),  64'(d_fill), 64'd0);
      tick();
      check($sformatf("D%0d data edge", k), 64'(d_out), 64'(exp_d));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
